// File: rtl/core2axi4l.sv
// core2axi4l: bridges a simple req/gnt core port onto an AXI4-Lite master.
// A single transaction is in flight at a time; the core sees one rvalid
// pulse per granted request, carrying read data (0 for writes) and an error flag.
module core2axi4l (
    input  logic        aclk,
    input  logic        aresetn,
    // Core side
    input  logic        core_req,
    output logic        core_gnt,
    input  logic        core_we,
    input  logic [3:0]  core_be,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,
    // AXI4-Lite write address channel
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    // AXI4-Lite write data channel
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    // AXI4-Lite write response channel
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    // AXI4-Lite read address channel
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    // AXI4-Lite read data channel
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_REQ    = 3'd1;
    localparam logic [2:0] WR_RESP   = 3'd2;
    localparam logic [2:0] RD_REQ    = 3'd3;
    localparam logic [2:0] RD_RESP   = 3'd4;
    localparam logic [2:0] CORE_RESP = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Handshake-facing outputs; everything is forced low while aresetn is held
    always_comb begin
        core_gnt    = aresetn && (state_q == IDLE) && core_req;
        awvalid     = aresetn && (state_q == WR_REQ) && !aw_done_q;
        wvalid      = aresetn && (state_q == WR_REQ) && !w_done_q;
        bready      = aresetn && (state_q == WR_RESP);
        arvalid     = aresetn && (state_q == RD_REQ);
        rready      = aresetn && (state_q == RD_RESP);
        core_rvalid = aresetn && (state_q == CORE_RESP);
        core_rdata  = (core_rvalid && !we_q) ? rdata_q : 32'h0;
        core_err    = core_rvalid && err_q;
        awaddr      = addr_q;
        araddr      = addr_q;
        wdata       = wdata_q;
        wstrb       = be_q;
    end

    // Next-state logic: request capture, per-channel done tracking, response capture
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (core_req) begin
                    addr_d    = core_addr;
                    we_d      = core_we;
                    be_d      = core_be;
                    wdata_d   = core_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = core_we ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; move on once both have gone
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid) begin
                    err_d   = bresp[1];
                    state_d = CORE_RESP;
                end
            end
            RD_REQ: begin
                if (arvalid && arready) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (rvalid) begin
                    rdata_d = rdata;
                    err_d   = rresp[1];
                    state_d = CORE_RESP;
                end
            end
            CORE_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: FSM and channel-done flags, synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Transaction payload and captured response; outputs gate these, so no reset
    always_ff @(posedge aclk) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
        err_q   <= err_d;
    end

endmodule

// File: tb/tb_core2axi4l.sv
// Bench for core2axi4l: reactive AXI4-Lite slave with programmable delays,
// a transaction-phase reference model compared every cycle, and directed
// scenarios with hand-computed literal expectations.
module tb_core2axi4l;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        core_req, core_gnt, core_we;
    logic [3:0]  core_be;
    logic [31:0] core_addr, core_wdata;
    logic        core_rvalid, core_err;
    logic [31:0] core_rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    core2axi4l dut (
        .aclk(aclk), .aresetn(aresetn),
        .core_req(core_req), .core_gnt(core_gnt), .core_we(core_we),
        .core_be(core_be), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Slave memory and the core-side reference memory
    logic [31:0] smem [0:15];
    logic [31:0] rmem [0:15];

    // Slave configuration
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] s_bresp = 2'b00, s_rresp = 2'b00;

    // Events recorded by the compare process
    int n_gnt = 0, n_rv = 0, gnt_cyc = 0, rv_cyc = 0;
    logic [31:0] rv_data;
    logic        rv_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_mem(input int i, input logic [31:0] v);
        smem[i] = v;
        rmem[i] = v;
    endtask

    // ---------------- Reactive AXI4-Lite slave ----------------
    initial begin
        bit h_aw, h_w, h_b, h_ar, h_r, rst_s;
        bit aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        logic [31:0] s_awaddr = 0, s_wdata = 0, s_raddr = 0;
        logic [3:0]  s_wstrb = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge aclk);
            h_aw  = awvalid && awready;
            h_w   = wvalid && wready;
            h_b   = bvalid && bready;
            h_ar  = arvalid && arready;
            h_r   = rvalid && rready;
            rst_s = !aresetn;
            if (h_aw) begin s_awaddr = awaddr; aw_cnt = 0; end
            else if (awvalid) aw_cnt++;
            if (h_w) begin s_wdata = wdata; s_wstrb = wstrb; w_cnt = 0; end
            else if (wvalid) w_cnt++;
            if (h_ar) begin s_raddr = araddr; ar_cnt = 0; end
            else if (arvalid) ar_cnt++;
            if (h_b) b_pend = 0; else if (b_pend) b_cnt++;
            if (h_r) r_pend = 0; else if (r_pend) r_cnt++;
            @(posedge aclk);
            #1;
            if (rst_s) begin
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (h_aw) aw_got = 1;
                if (h_w) w_got = 1;
                if (aw_got && w_got) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) smem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                end
                if (h_ar) begin r_pend = 1; r_cnt = 0; end
            end
            awready = awvalid && (aw_cnt >= aw_dly);
            wready  = wvalid && (w_cnt >= w_dly);
            arready = arvalid && (ar_cnt >= ar_dly);
            bvalid  = b_pend && (b_cnt >= b_dly);
            bresp   = s_bresp;
            rvalid  = r_pend && (r_cnt >= r_dly);
            rdata   = rvalid ? smem[s_raddr[5:2]] : 32'h0;
            rresp   = s_rresp;
        end
    end

    // ---------------- Reference model and per-cycle compare ----------------
    bit m_active = 0, m_we = 0, m_aw_done = 0, m_w_done = 0, m_ar_done = 0;
    bit m_resp_due = 0, m_resp_err = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_resp_data = 0, m_exp_rd = 0;
    logic [3:0]  m_be = 0;

    initial begin
        bit e_gnt, e_aw, e_w, e_b, e_ar, e_r, e_cv;
        forever begin
            @(negedge aclk);
            e_gnt = aresetn && !m_active && !m_resp_due && core_req;
            e_aw  = aresetn && m_active && m_we && !m_aw_done;
            e_w   = aresetn && m_active && m_we && !m_w_done;
            e_b   = aresetn && m_active && m_we && m_aw_done && m_w_done;
            e_ar  = aresetn && m_active && !m_we && !m_ar_done;
            e_r   = aresetn && m_active && !m_we && m_ar_done;
            e_cv  = aresetn && m_resp_due;
            chkb("core_gnt", core_gnt, e_gnt);
            chkb("awvalid", awvalid, e_aw);
            chkb("wvalid", wvalid, e_w);
            chkb("bready", bready, e_b);
            chkb("arvalid", arvalid, e_ar);
            chkb("rready", rready, e_r);
            chkb("core_rvalid", core_rvalid, e_cv);
            chk("core_rdata", core_rdata, e_cv ? m_resp_data : 32'h0);
            chkb("core_err", core_err, e_cv && m_resp_err);
            if (e_aw) chk("awaddr", awaddr, m_addr);
            if (e_w) begin
                chk("wdata", wdata, m_wdata);
                chk("wstrb", {28'h0, wstrb}, {28'h0, m_be});
            end
            if (e_ar) chk("araddr", araddr, m_addr);
            if (e_cv && !m_we) chk("rd_vs_mem", core_rdata, m_exp_rd);
            if (core_gnt === 1'b1) begin n_gnt++; gnt_cyc = cyc; end
            if (core_rvalid === 1'b1) begin
                n_rv++; rv_cyc = cyc; rv_data = core_rdata; rv_err = core_err;
            end
            // Advance the model to the next cycle
            if (!aresetn) begin
                m_active = 0; m_resp_due = 0; m_aw_done = 0; m_w_done = 0; m_ar_done = 0;
            end else if (m_resp_due) begin
                m_resp_due = 0;
            end else if (!m_active) begin
                if (core_req) begin
                    m_active = 1; m_we = core_we; m_addr = core_addr; m_be = core_be;
                    m_wdata = core_wdata; m_aw_done = 0; m_w_done = 0; m_ar_done = 0;
                    if (core_we) begin
                        for (int b = 0; b < 4; b++)
                            if (core_be[b]) rmem[core_addr[5:2]][8*b +: 8] = core_wdata[8*b +: 8];
                    end else begin
                        m_exp_rd = rmem[core_addr[5:2]];
                    end
                end
            end else if (m_we) begin
                if (e_b && bvalid) begin
                    m_resp_data = 32'h0;
                    m_resp_err  = (bresp == 2'b10) || (bresp == 2'b11);
                    m_active = 0; m_resp_due = 1;
                end
                if (e_aw && awready) m_aw_done = 1;
                if (e_w && wready) m_w_done = 1;
            end else begin
                if (e_r && rvalid) begin
                    m_resp_data = rdata;
                    m_resp_err  = (rresp == 2'b10) || (rresp == 2'b11);
                    m_active = 0; m_resp_due = 1;
                end
                if (e_ar && arready) m_ar_done = 1;
            end
        end
    end

    // ---------------- Directed helpers ----------------
    task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d);
        int k = 0;
        core_req = 1; core_we = we; core_addr = a; core_be = be; core_wdata = d;
        @(negedge aclk);
        while (!core_gnt && k < 20) begin
            @(posedge aclk); #1; @(negedge aclk); k++;
        end
        chkb("issue_gnt", core_gnt, 1'b1);
        tick();
        core_req = 0;
    endtask

    task automatic await_rv(input int rv0);
        int k = 0;
        while (n_rv == rv0 && k < 60) begin tick(); k++; end
        chkb("rv_arrived", n_rv != rv0, 1'b1);
    endtask

    task automatic run_txn(input string nm, input logic we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d, input int lat,
                           input logic [31:0] exp_data, input logic exp_err);
        int rv0 = n_rv;
        int g0 = n_gnt;
        issue(we, a, be, d);
        await_rv(rv0);
        repeat (3) tick();
        chk({nm, "_one_rv"}, n_rv - rv0, 1);
        chk({nm, "_one_gnt"}, n_gnt - g0, 1);
        chk({nm, "_latency"}, rv_cyc - gnt_cyc, lat);
        chk({nm, "_rdata"}, rv_data, exp_data);
        chkb({nm, "_err"}, rv_err, exp_err);
    endtask

    task automatic rand_payload();
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        core_be    = 4'($urandom_range(0, 15));
        core_wdata = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- Stimulus ----------------
    initial begin
        int rv0, g0, k, t, guard;
        bit seen, granted;
        logic [6:1] aw_s, w_s, b_s, cv_s;
        aresetn = 0; core_req = 1; core_we = 0; core_be = 4'hF;
        core_addr = 32'h0; core_wdata = 32'h0;
        for (int i = 0; i < 16; i++) set_mem(i, 32'hA5A50000 + 32'(i) * 32'h01010101);

        // Reset state with a request pending
        repeat (3) begin
            @(negedge aclk);
            chkb("rst_gnt", core_gnt, 1'b0);
            chkb("rst_awvalid", awvalid, 1'b0);
            chkb("rst_arvalid", arvalid, 1'b0);
            chkb("rst_core_rvalid", core_rvalid, 1'b0);
            chk("rst_core_rdata", core_rdata, 32'h0);
        end
        tick();
        aresetn = 1; core_req = 0;
        tick();

        set_mem(0, 32'hDEADBEEF);
        set_mem(1, 32'hCAFEF00D);
        set_mem(2, 32'h11223344);
        set_mem(3, 32'h0BADF00D);

        // Zero-wait read
        run_txn("rd0", 1'b0, 32'h100, 4'hF, 32'h0, 3, 32'hDEADBEEF, 1'b0);

        // Write with W accepted before AW
        aw_dly = 3; w_dly = 0; b_dly = 0;
        rv0 = n_rv;
        issue(1'b1, 32'h200, 4'hF, 32'h12345678);
        for (int i = 1; i <= 6; i++) begin
            @(negedge aclk);
            aw_s[i] = awvalid; w_s[i] = wvalid; b_s[i] = bready; cv_s[i] = core_rvalid;
        end
        tick();
        chkb("w1_wvalid_t1", w_s[1], 1'b1);
        chkb("w1_wvalid_t2", w_s[2], 1'b0);
        chkb("w1_awvalid_t4", aw_s[4], 1'b1);
        chkb("w1_awvalid_t5", aw_s[5], 1'b0);
        chkb("w1_bready_t4", b_s[4], 1'b0);
        chkb("w1_bready_t5", b_s[5], 1'b1);
        chkb("w1_rvalid_t6", cv_s[6], 1'b1);
        chk("w1_one_rv", n_rv - rv0, 1);
        chk("w1_slave_mem", smem[0], 32'h12345678);
        aw_dly = 0;

        // Error responses and EXOKAY
        s_bresp = 2'b10;
        run_txn("wr_slverr", 1'b1, 32'h20C, 4'hF, 32'h600DCAFE, 3, 32'h0, 1'b1);
        s_bresp = 2'b00; s_rresp = 2'b11;
        run_txn("rd_decerr", 1'b0, 32'h10C, 4'hF, 32'h0, 3, 32'h600DCAFE, 1'b1);
        s_rresp = 2'b01;
        run_txn("rd_exokay", 1'b0, 32'h10C, 4'hF, 32'h0, 3, 32'h600DCAFE, 1'b0);
        s_rresp = 2'b00;

        // Read backpressure with core_req held and core_addr wandering
        rv0 = n_rv; g0 = n_gnt; ar_dly = 5; r_dly = 3;
        core_req = 1; core_we = 0; core_addr = 32'h104; core_be = 4'hF;
        @(negedge aclk);
        chkb("bp_gnt", core_gnt, 1'b1);
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            tick();
            core_addr = 32'h0000_0F00 + 32'(k); core_wdata = $urandom; k++;
            @(negedge aclk);
            if (arvalid) chk("bp_araddr", araddr, 32'h104);
            chkb("bp_no_gnt", core_gnt, 1'b0);
            seen = core_rvalid;
        end
        tick();
        core_req = 0;
        repeat (2) tick();
        chk("bp_one_gnt", n_gnt - g0, 1);
        chk("bp_one_rv", n_rv - rv0, 1);
        chk("bp_latency", rv_cyc - gnt_cyc, 11);
        chk("bp_rdata", rv_data, 32'hCAFEF00D);
        ar_dly = 0; r_dly = 0;

        // Reset while waiting in WR_RESP
        b_dly = 4; rv0 = n_rv;
        issue(1'b1, 32'h208, 4'b0011, 32'h55AA55AA);
        tick();
        tick();
        aresetn = 0; core_req = 1; core_we = 0; core_addr = 32'h100;
        @(negedge aclk);
        chkb("rr_gnt", core_gnt, 1'b0);
        chkb("rr_awvalid", awvalid, 1'b0);
        chkb("rr_wvalid", wvalid, 1'b0);
        chkb("rr_bready", bready, 1'b0);
        chkb("rr_arvalid", arvalid, 1'b0);
        chkb("rr_rready", rready, 1'b0);
        chkb("rr_core_rvalid", core_rvalid, 1'b0);
        chkb("rr_core_err", core_err, 1'b0);
        chk("rr_core_rdata", core_rdata, 32'h0);
        tick();
        aresetn = 1; core_req = 0; b_dly = 0;
        repeat (8) tick();
        chk("rr_no_rv", n_rv - rv0, 0);
        run_txn("rr_after", 1'b0, 32'h208, 4'hF, 32'h0, 3, 32'h112255AA, 1'b0);

        // Back-to-back random stream against the memory model
        rv0 = n_rv; g0 = n_gnt; t = 0; guard = 0;
        rand_payload();
        core_req = 1;
        while (t < 100 && guard < 5000) begin
            @(negedge aclk);
            guard++;
            granted = core_gnt;
            if (granted) begin
                t++;
                aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
                b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
                r_dly = $urandom_range(0, 3);
                s_bresp = 2'($urandom_range(0, 1)); s_rresp = 2'($urandom_range(0, 1));
            end
            tick();
            if (granted) begin
                rand_payload();
                core_req = ($urandom_range(0, 3) != 0);
            end else if (!core_req) begin
                core_req = 1;
            end
        end
        core_req = 0;
        k = 0;
        while ((n_rv - rv0) < t && k < 100) begin tick(); k++; end
        repeat (3) tick();
        chk("stream_gnts", n_gnt - g0, 100);
        chk("stream_rvs", n_rv - rv0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
